cpu_mem_responder: RTL
======================

CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 Parameter DW, default 16: data word width.
REQ-002 Parameter AW, default 13: address width.
REQ-003 Parameter DEPTH, default 8192: implemented words, DEPTH <= 2**AW.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 load_valid  input  1: loader word offered.
REQ-007 load_data  input  DW: loader word.
REQ-008 load_last  input  1: qualifies final loader word.
REQ-009 load_ready  output  1: responder accepts loader word.
REQ-010 cpu_hold  output  1: holds the CPU in reset while memory is being loaded.
REQ-011 addr_toRAM  input  AW: CPU address.
REQ-012 data_toRAM  input  DW: CPU write data.
REQ-013 wrEn  input  1: CPU write enable.
REQ-014 data_fromRAM  output  DW: registered read data.
REQ-015 load_ovf  output  1: sticky, loader ran past DEPTH-1.
REQ-016 addr_err  output  1: sticky, CPU access to address >= DEPTH.

Function
REQ-017 The block SHALL have a two-state FSM: LOAD and RUN.
REQ-018 LOAD: load_ready=1, cpu_hold=1; CPU bus ignored (no writes, data_fromRAM holds its value).
REQ-019 Load transfer occurs when load_valid & load_ready at a rising edge; word written to mem[load_ptr]; load_ptr increments by 1.
REQ-020 load_ptr SHALL be 0 on entry to LOAD.
REQ-021 Transfer with load_last=1: LOAD->RUN on the same edge.
REQ-022 Transfer at load_ptr=DEPTH-1 with load_last=0: word written, load_ovf set, LOAD->RUN; load_ptr does not wrap.
REQ-023 load_valid=0: no write, no pointer change, stay in LOAD indefinitely.
REQ-024 RUN: load_ready=0, cpu_hold=0; loader inputs ignored.
REQ-025 RUN read: data_fromRAM = mem[addr_toRAM] registered, valid the cycle after the address is presented (1-cycle latency), every cycle regardless of wrEn.
REQ-026 RUN write: wrEn=1 writes data_toRAM to mem[addr_toRAM] at the edge.
REQ-027 Same-address read and write in one cycle: read-first; data_fromRAM returns old contents, new value visible on the following read.
REQ-028 addr_toRAM >= DEPTH in RUN: write suppressed, data_fromRAM loads 0, addr_err set.
REQ-029 load_ovf and addr_err SHALL clear only on reset.
REQ-030 RUN is terminal; only reset returns the FSM to LOAD.

Reset
REQ-031 rst=0 SHALL immediately force: FSM=LOAD, load_ptr=0, load_ready=1, cpu_hold=1, data_fromRAM=0, load_ovf=0, addr_err=0.
REQ-032 Memory contents SHALL NOT be cleared by reset; reset mid-load or mid-run preserves written words.
REQ-033 Reset asserted mid-load: next load after deassertion restarts at address 0.
REQ-034 Deassertion SHALL be synchronous to clk in effect; first transfer possible on first rising edge after rst=1.

Verification
REQ-035 Load 0x0003,0x0010,0xFEED with last on 3rd -> mem[0..2] match, cpu_hold falls the cycle after 3rd transfer, load_ready=0.
REQ-036 RUN, read addr 2 in cycle N -> data_fromRAM=0xFEED in cycle N+1; write 0xDEAF to 147 then read 147 -> 0xDEAF.
REQ-037 Same cycle wrEn=1 addr 1 data 0x00FF with mem[1]=0x0010 -> data_fromRAM=0x0010 next cycle, 0x00FF on following read.
REQ-038 DEPTH=16, load 17 words without last -> words 0..15 written, load_ovf=1 after 16th, RUN entered, 17th ignored.
REQ-039 DEPTH=16, RUN write/read addr 20 -> no write, data_fromRAM=0, addr_err=1 until reset.
REQ-040 rst low after 2 of 4 load words, then reload 0xAAAA -> mem[0]=0xAAAA, mem[1] retains earlier word, all outputs at reset values during rst=0.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: loads a word memory from a streaming loader while the
// CPU is held, then serves single-cycle registered CPU reads and writes.
module cpu_mem_responder #(
   parameter int DW    = 16,
   parameter int AW    = 13,
   parameter int DEPTH = 8192
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   input  logic          load_last,
   output logic          load_ready,
   output logic          cpu_hold,
   input  logic [AW-1:0] addr_toRAM,
   input  logic [DW-1:0] data_toRAM,
   input  logic          wrEn,
   output logic [DW-1:0] data_fromRAM,
   output logic          load_ovf,
   output logic          addr_err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DepthW = (AW+1)'(DEPTH);
   localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t state;
   logic [IW-1:0] loadPtr;
   logic [DW-1:0] mem [DEPTH];

   logic          inRange;
   logic [IW-1:0] cpuIdx;
   logic          loadXfer;
   logic          atLast;
   logic          memWe;
   logic [IW-1:0] memIdx;
   logic [DW-1:0] memWd;

   assign inRange  = {1'b0, addr_toRAM} < DepthW;
   assign cpuIdx   = addr_toRAM[IW-1:0];
   assign loadXfer = (state == LOAD) & load_valid;
   assign atLast   = (loadPtr == LastIdx);

   // Single write port: loader owns it in LOAD, CPU in RUN; nothing
   // is written while reset is held so stored words survive it.
   always_comb begin
      memWe  = 1'b0;
      memIdx = loadPtr;
      memWd  = load_data;
      if (rst) begin
         if (state == LOAD) begin
            memWe = load_valid;
         end else begin
            memWe  = wrEn & inRange;
            memIdx = cpuIdx;
            memWd  = data_toRAM;
         end
      end
   end

   // Memory array is never reset.
   always_ff @(posedge clk) begin
      if (memWe) mem[memIdx] <= memWd;
   end

   // Load/run FSM with registered handshake, read data and sticky flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= LOAD;
         loadPtr      <= '0;
         load_ready   <= 1'b1;
         cpu_hold     <= 1'b1;
         data_fromRAM <= '0;
         load_ovf     <= 1'b0;
         addr_err     <= 1'b0;
      end else begin
         unique case (state)
            LOAD: begin
               if (loadXfer) begin
                  if (!atLast) loadPtr <= loadPtr + 1'b1;
                  if (load_last || atLast) begin
                     state      <= RUN;
                     load_ready <= 1'b0;
                     cpu_hold   <= 1'b0;
                  end
                  if (!load_last && atLast) load_ovf <= 1'b1;
               end
            end
            RUN: begin
               if (inRange) begin
                  data_fromRAM <= mem[cpuIdx];
               end else begin
                  data_fromRAM <= '0;
                  addr_err     <= 1'b1;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule
